// File: rtl/sa_job_launcher_if.sv
// Descriptor intake, array control and completion-report signals of the systolic-array job launcher.
interface sa_job_launcher_if #(
  parameter int MAX_M_SIZE_LOG2 = 9,
  parameter int MAX_K_SIZE_LOG2 = 9,
  parameter int MAX_N_SIZE_LOG2 = 9,
  parameter int CYC_BWIDTH      = 32
);
  logic                       JOB_VALID_in;
  logic                       JOB_READY_out;
  logic [MAX_M_SIZE_LOG2-1:0] JOB_M_in;
  logic [MAX_K_SIZE_LOG2-1:0] JOB_K_in;
  logic [MAX_N_SIZE_LOG2-1:0] JOB_N_in;
  logic                       START_out;
  logic [MAX_M_SIZE_LOG2-1:0] M_SIZE_out;
  logic [MAX_K_SIZE_LOG2-1:0] K_SIZE_out;
  logic [MAX_N_SIZE_LOG2-1:0] N_SIZE_out;
  logic                       STALL_out;
  logic                       IS_FINISHED_in;
  logic                       DONE_VALID_out;
  logic                       DONE_READY_in;
  logic [CYC_BWIDTH-1:0]      DONE_CYCLES_out;
  logic [1:0]                 DONE_STATUS_out;
  logic                       BUSY_out;
  logic [15:0]                JOB_COUNT_out;

  modport slave (
    input  JOB_VALID_in, JOB_M_in, JOB_K_in, JOB_N_in, IS_FINISHED_in, DONE_READY_in,
    output JOB_READY_out, START_out, M_SIZE_out, K_SIZE_out, N_SIZE_out, STALL_out,
           DONE_VALID_out, DONE_CYCLES_out, DONE_STATUS_out, BUSY_out, JOB_COUNT_out
  );

  modport master (
    output JOB_VALID_in, JOB_M_in, JOB_K_in, JOB_N_in, IS_FINISHED_in, DONE_READY_in,
    input  JOB_READY_out, START_out, M_SIZE_out, K_SIZE_out, N_SIZE_out, STALL_out,
           DONE_VALID_out, DONE_CYCLES_out, DONE_STATUS_out, BUSY_out, JOB_COUNT_out
  );
endinterface

// File: rtl/sa_job_launcher.sv
// Queues matrix-job descriptors and runs them one at a time on the systolic array; START 2 cycles after a push into an idle launcher.
// JOB_READY_out drops while the descriptor queue is full; a completion report holds until DONE_READY_in.
module sa_job_launcher #(
  parameter int MAX_M_SIZE_LOG2 = 9,
  parameter int MAX_K_SIZE_LOG2 = 9,
  parameter int MAX_N_SIZE_LOG2 = 9,
  parameter int FIFO_DEPTH_LOG2 = 2,
  parameter int CYC_BWIDTH      = 32,
  parameter int TIMEOUT_CYCLES  = 100000
) (
  input logic              CLK,
  input logic              RST,
  sa_job_launcher_if.slave bus
);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0] DEPTH_CNT = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [CYC_BWIDTH-1:0]    TIMEOUT   = CYC_BWIDTH'(TIMEOUT_CYCLES);
  localparam logic [1:0] STATUS_OK      = 2'b00;
  localparam logic [1:0] STATUS_TIMEOUT = 2'b01;
  localparam logic [1:0] STATUS_ZERO    = 2'b10;

  typedef struct packed {
    logic [MAX_M_SIZE_LOG2-1:0] m;
    logic [MAX_K_SIZE_LOG2-1:0] k;
    logic [MAX_N_SIZE_LOG2-1:0] n;
  } desc_t;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, REPORT} state_t;

  desc_t                      mem [DEPTH];
  desc_t                      job_dat;
  desc_t                      head;
  desc_t                      size_r;
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   count;
  logic                       push;
  logic                       pop;
  logic                       head_zero;
  state_t                     state;
  logic [CYC_BWIDTH-1:0]      cyc_cnt;
  logic [CYC_BWIDTH-1:0]      cyc_next;
  logic                       start_r;
  logic                       done_vld_r;
  logic [CYC_BWIDTH-1:0]      done_cycles_r;
  logic [1:0]                 done_status_r;
  logic [15:0]                job_count_r;

  assign job_dat   = {bus.JOB_M_in, bus.JOB_K_in, bus.JOB_N_in};
  assign push      = bus.JOB_VALID_in && bus.JOB_READY_out;
  assign pop       = (state == IDLE) && (count != '0);
  assign head      = mem[rd_ptr];
  assign head_zero = (head.m == '0) || (head.k == '0) || (head.n == '0);
  assign cyc_next  = (&cyc_cnt) ? cyc_cnt : cyc_cnt + CYC_BWIDTH'(1);

  assign bus.JOB_READY_out   = (count < DEPTH_CNT);
  assign bus.START_out       = start_r;
  assign bus.M_SIZE_out      = size_r.m;
  assign bus.K_SIZE_out      = size_r.k;
  assign bus.N_SIZE_out      = size_r.n;
  assign bus.STALL_out       = 1'b0;
  assign bus.DONE_VALID_out  = done_vld_r;
  assign bus.DONE_CYCLES_out = done_cycles_r;
  assign bus.DONE_STATUS_out = done_status_r;
  assign bus.BUSY_out        = (state != IDLE) || (count != '0);
  assign bus.JOB_COUNT_out   = job_count_r;

  // Descriptor storage is not reset: pointers and occupancy decide what is visible.
  always_ff @(posedge CLK) begin
    if (push && !RST) begin
      mem[wr_ptr] <= job_dat;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      state         <= IDLE;
      cyc_cnt       <= '0;
      start_r       <= 1'b0;
      done_vld_r    <= 1'b0;
      done_cycles_r <= '0;
      done_status_r <= STATUS_OK;
      size_r        <= '0;
      job_count_r   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_DEPTH_LOG2'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_DEPTH_LOG2'(1);
      case ({push, pop})
        2'b10:   count <= count + (FIFO_DEPTH_LOG2 + 1)'(1);
        2'b01:   count <= count - (FIFO_DEPTH_LOG2 + 1)'(1);
        default: count <= count;
      endcase

      start_r <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            size_r <= head;
            if (head_zero) begin
              done_cycles_r <= '0;
              done_status_r <= STATUS_ZERO;
              done_vld_r    <= 1'b1;
              state         <= REPORT;
            end else begin
              start_r <= 1'b1;
              state   <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          cyc_cnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          cyc_cnt <= cyc_next;
          // Completion in the timeout cycle still counts as a clean finish.
          if (bus.IS_FINISHED_in) begin
            done_cycles_r <= cyc_next;
            done_status_r <= STATUS_OK;
            done_vld_r    <= 1'b1;
            state         <= REPORT;
          end else if (cyc_next == TIMEOUT) begin
            done_cycles_r <= TIMEOUT;
            done_status_r <= STATUS_TIMEOUT;
            done_vld_r    <= 1'b1;
            state         <= REPORT;
          end
        end
        REPORT: begin
          if (bus.DONE_READY_in) begin
            done_vld_r  <= 1'b0;
            job_count_r <= job_count_r + 16'd1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sa_job_launcher.sv
// Bench for sa_job_launcher: directed job table, hand-built corner sequences and randomized traffic
// checked every cycle against a transaction-level model of queued jobs and their expected reports.
module tb_sa_job_launcher;
  localparam int TMO = 20;
  localparam int W   = 9;

  typedef struct packed {
    logic [W-1:0] m;
    logic [W-1:0] k;
    logic [W-1:0] n;
    logic [7:0]   f;   // WAIT cycle on which the array finishes; 0 = never
  } job_t;

  typedef struct packed {
    logic [W-1:0] m;
    logic [W-1:0] k;
    logic [W-1:0] n;
    logic [7:0]   f;
    logic         exp_start;
    logic [7:0]   exp_cycles;
    logic [1:0]   exp_status;
  } vec_t;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  sa_job_launcher_if #(.MAX_M_SIZE_LOG2(W), .MAX_K_SIZE_LOG2(W), .MAX_N_SIZE_LOG2(W),
                       .CYC_BWIDTH(32)) bus ();

  sa_job_launcher #(
    .MAX_M_SIZE_LOG2(W), .MAX_K_SIZE_LOG2(W), .MAX_N_SIZE_LOG2(W),
    .FIFO_DEPTH_LOG2(2), .CYC_BWIDTH(32), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          n_start = 0;
  int          last_acc = -10;
  logic [15:0] reported = '0;
  int          rdy_mode = 0;    // 0 always ready, 1 random, 2 held low
  int          stray_mode = 0;  // IS_FINISHED outside WAIT: 0 none, 1 random, 2 constant 1
  bit          active = 0;
  bit          cur_started = 0;
  int          wk = 0;
  int          act_f = 0;
  bit          prev_vld = 0;
  bit          prev_rdy = 0;
  bit          prev_start = 0;
  logic [31:0] prev_cyc = '0;
  logic [1:0]  prev_st = '0;
  logic [31:0] last_cycles = '0;
  logic [1:0]  last_status = '0;
  job_t        model_q[$];

  function automatic int lim_of(input int f);
    return (f == 0 || f > TMO) ? TMO : f;
  endfunction

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Runs at every sample point: checks against the model, then drives array and report-sink inputs.
  task automatic monitor();
    job_t e;
    bit   zero;
    bit   fin;
    bit   in_win;
    bit   rdy;
    cyc++;
    check("busy", bus.BUSY_out, model_q.size() != 0);
    if (bus.JOB_READY_out) check("ready_not_full", model_q.size() <= 4, 1);
    else                   check("ready_full", model_q.size() >= 4, 1);
    check("stall", bus.STALL_out, 0);
    check("job_count", bus.JOB_COUNT_out, reported);
    if (prev_vld && !prev_rdy) begin
      check("done_hold_valid", bus.DONE_VALID_out, 1);
      check("done_hold_cycles", bus.DONE_CYCLES_out, prev_cyc);
      check("done_hold_status", bus.DONE_STATUS_out, prev_st);
    end

    fin = 1'b0;
    in_win = 1'b0;
    if (bus.START_out) begin
      n_start++;
      check("start_single", prev_start, 0);
      check("start_turnaround", (cyc - last_acc) >= 2, 1);
      check("start_has_job", model_q.size() != 0, 1);
      if (model_q.size() != 0) begin
        e = model_q[0];
        check("start_relaunch", cur_started, 0);
        check("start_m", bus.M_SIZE_out, e.m);
        check("start_k", bus.K_SIZE_out, e.k);
        check("start_n", bus.N_SIZE_out, e.n);
        cur_started = 1'b1;
        active = 1'b1;
        wk = 0;
        act_f = int'(e.f);
      end
    end else if (active) begin
      wk++;
      in_win = 1'b1;
      fin = (wk == act_f);
      if (wk >= lim_of(act_f)) active = 1'b0;
    end
    if (!in_win) begin
      if (stray_mode == 2)      fin = 1'b1;
      else if (stray_mode == 1) fin = ($urandom_range(0, 3) == 0);
    end
    bus.IS_FINISHED_in = fin;

    if (rdy_mode == 0)      rdy = 1'b1;
    else if (rdy_mode == 1) rdy = ($urandom_range(0, 1) == 1);
    else                    rdy = 1'b0;
    bus.DONE_READY_in = rdy;
    if (bus.DONE_VALID_out && rdy) begin
      check("report_has_job", model_q.size() != 0, 1);
      if (model_q.size() != 0) begin
        e = model_q.pop_front();
        zero = (e.m == 0) || (e.k == 0) || (e.n == 0);
        check("report_launched", cur_started, !zero);
        check("report_cycles", bus.DONE_CYCLES_out, zero ? 0 : lim_of(int'(e.f)));
        check("report_status", bus.DONE_STATUS_out,
              zero ? 2 : ((e.f == 0 || int'(e.f) > TMO) ? 1 : 0));
        check("report_m", bus.M_SIZE_out, e.m);
        check("report_k", bus.K_SIZE_out, e.k);
        check("report_n", bus.N_SIZE_out, e.n);
        last_cycles = bus.DONE_CYCLES_out;
        last_status = bus.DONE_STATUS_out;
        reported++;
        last_acc = cyc;
        cur_started = 1'b0;
        active = 1'b0;
      end
    end
    prev_vld   = bus.DONE_VALID_out;
    prev_rdy   = rdy;
    prev_cyc   = bus.DONE_CYCLES_out;
    prev_st    = bus.DONE_STATUS_out;
    prev_start = bus.START_out;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    monitor();
  endtask

  task automatic offer(input job_t j, output bit acc);
    bus.JOB_VALID_in = 1'b1;
    bus.JOB_M_in = j.m;
    bus.JOB_K_in = j.k;
    bus.JOB_N_in = j.n;
    acc = bus.JOB_READY_out;
    if (acc) model_q.push_back(j);
    step();
    bus.JOB_VALID_in = 1'b0;
  endtask

  task automatic drain(input string nm, input int budget);
    int b = 0;
    rdy_mode = 0;
    while (model_q.size() != 0 && b < budget) begin
      step();
      b++;
    end
    check(nm, model_q.size(), 0);
  endtask

  task automatic wait_start(input string nm, input int budget);
    int b = 0;
    while (!bus.START_out && b < budget) begin
      step();
      b++;
    end
    check(nm, bus.START_out, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vec [9];
    job_t        j;
    bit          acc;
    int          lat;
    int          bud;
    int          ns;
    logic [15:0] cnt_before;
    int          rep_before;

    vec[0] = '{9'd128, 9'd128, 9'd128, 8'd5,  1'b1, 8'd5,  2'b00};
    vec[1] = '{9'd3,   9'd4,   9'd5,   8'd1,  1'b1, 8'd1,  2'b00};
    vec[2] = '{9'd511, 9'd1,   9'd2,   8'd20, 1'b1, 8'd20, 2'b00};
    vec[3] = '{9'd7,   9'd7,   9'd7,   8'd0,  1'b1, 8'd20, 2'b01};
    vec[4] = '{9'd9,   9'd8,   9'd7,   8'd21, 1'b1, 8'd20, 2'b01};
    vec[5] = '{9'd0,   9'd64,  9'd64,  8'd3,  1'b0, 8'd0,  2'b10};
    vec[6] = '{9'd5,   9'd0,   9'd3,   8'd3,  1'b0, 8'd0,  2'b10};
    vec[7] = '{9'd1,   9'd1,   9'd0,   8'd3,  1'b0, 8'd0,  2'b10};
    vec[8] = '{9'd1,   9'd1,   9'd1,   8'd19, 1'b1, 8'd19, 2'b00};

    RST = 1'b1;
    bus.JOB_VALID_in = 1'b0;
    bus.JOB_M_in = '0;
    bus.JOB_K_in = '0;
    bus.JOB_N_in = '0;
    bus.IS_FINISHED_in = 1'b0;
    bus.DONE_READY_in = 1'b0;
    step();
    step();
    check("rst_start", bus.START_out, 0);
    check("rst_done_valid", bus.DONE_VALID_out, 0);
    check("rst_cycles", bus.DONE_CYCLES_out, 0);
    check("rst_status", bus.DONE_STATUS_out, 0);
    check("rst_m", bus.M_SIZE_out, 0);
    check("rst_ready", bus.JOB_READY_out, 1);
    RST = 1'b0;

    // One job at a time from the table: latency, report payload, job count.
    for (int i = 0; i < 9; i++) begin
      j = '{m: vec[i].m, k: vec[i].k, n: vec[i].n, f: vec[i].f};
      cnt_before = reported;
      ns = n_start;
      offer(j, acc);
      check("vec_accept", acc, 1);
      lat = 1;
      while (!bus.START_out && !bus.DONE_VALID_out && lat < 60) begin
        step();
        lat++;
      end
      check("vec_start", bus.START_out, vec[i].exp_start);
      check("vec_latency", lat, 2);
      bud = 0;
      while (reported == cnt_before && bud < 100) begin
        step();
        bud++;
      end
      check("vec_cycles", last_cycles, vec[i].exp_cycles);
      check("vec_status", last_status, vec[i].exp_status);
      step();
      check("vec_job_count", bus.JOB_COUNT_out, cnt_before + 16'd1);
      check("vec_starts", n_start - ns, vec[i].exp_start);
    end

    // Queue fills behind a running job: four accepted, fifth refused, launched in order.
    j = '{m: 9'd11, k: 9'd12, n: 9'd13, f: 8'd0};
    offer(j, acc);
    wait_start("fill_first_start", 20);
    for (int i = 0; i < 5; i++) begin
      j = '{m: W'(20 + i), k: W'(30 + i), n: W'(40 + i), f: 8'd3};
      offer(j, acc);
      check("fill_accept", acc, i < 4);
    end
    check("fill_ready_low", bus.JOB_READY_out, 0);
    ns = n_start;
    drain("fill_drain", 400);
    check("fill_starts", n_start - ns, 4);

    // Report held by the consumer: payload frozen, queued job not launched.
    rdy_mode = 2;
    j = '{m: 9'd100, k: 9'd200, n: 9'd300, f: 8'd3};
    offer(j, acc);
    j = '{m: 9'd2, k: 9'd3, n: 9'd4, f: 8'd2};
    offer(j, acc);
    bud = 0;
    while (!bus.DONE_VALID_out && bud < 50) begin
      step();
      bud++;
    end
    check("hold_valid", bus.DONE_VALID_out, 1);
    ns = n_start;
    repeat (10) step();
    check("hold_valid_after", bus.DONE_VALID_out, 1);
    check("hold_cycles", bus.DONE_CYCLES_out, 3);
    check("hold_status", bus.DONE_STATUS_out, 0);
    check("hold_no_start", n_start - ns, 0);
    drain("hold_drain", 200);
    ns = n_start;
    stray_mode = 2;
    repeat (4) step();
    stray_mode = 0;
    step();
    check("stray_busy", bus.BUSY_out, 0);
    check("stray_valid", bus.DONE_VALID_out, 0);
    check("stray_start", n_start - ns, 0);

    // Reset while waiting with two jobs queued, plus a push offered in the reset cycle.
    j = '{m: 9'd50, k: 9'd51, n: 9'd52, f: 8'd0};
    offer(j, acc);
    wait_start("rst_job_start", 20);
    j = '{m: 9'd60, k: 9'd61, n: 9'd62, f: 8'd0};
    offer(j, acc);
    j = '{m: 9'd70, k: 9'd71, n: 9'd72, f: 8'd0};
    offer(j, acc);
    step();
    step();
    RST = 1'b1;
    bus.JOB_VALID_in = 1'b1;
    bus.JOB_M_in = 9'd1;
    bus.JOB_K_in = 9'd2;
    bus.JOB_N_in = 9'd3;
    model_q.delete();
    reported = '0;
    active = 1'b0;
    cur_started = 1'b0;
    prev_vld = 1'b0;
    prev_start = 1'b0;
    step();
    RST = 1'b0;
    bus.JOB_VALID_in = 1'b0;
    check("midrst_start", bus.START_out, 0);
    check("midrst_valid", bus.DONE_VALID_out, 0);
    check("midrst_busy", bus.BUSY_out, 0);
    check("midrst_cycles", bus.DONE_CYCLES_out, 0);
    check("midrst_status", bus.DONE_STATUS_out, 0);
    check("midrst_m", bus.M_SIZE_out, 0);
    check("midrst_k", bus.K_SIZE_out, 0);
    check("midrst_n", bus.N_SIZE_out, 0);
    check("midrst_count", bus.JOB_COUNT_out, 0);
    ns = n_start;
    repeat (30) step();
    check("midrst_no_start", n_start - ns, 0);
    check("midrst_no_report", bus.DONE_VALID_out, 0);

    // Randomized traffic, consumer stalls and stray completions.
    rep_before = int'(reported);
    rdy_mode = 1;
    stray_mode = 1;
    repeat (2500) begin
      if ($urandom_range(0, 2) == 0) begin
        j.m = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom_range(1, 511));
        j.k = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom_range(1, 511));
        j.n = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom_range(1, 511));
        j.f = 8'($urandom_range(0, 25));
        offer(j, acc);
      end else begin
        step();
      end
    end
    stray_mode = 0;
    drain("rand_drain", 2000);
    check("rand_progress", (int'(reported) - rep_before) > 20, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sa_job_launcher.md
SA_JOB_LAUNCHER -- requirements
Module: sa_job_launcher

Interface
REQ-001 SHALL have parameters (name, default, meaning): MAX_M_SIZE_LOG2, 9, M size field width; MAX_K_SIZE_LOG2, 9, K size field width; MAX_N_SIZE_LOG2, 9, N size field width.
REQ-002 SHALL have parameters: FIFO_DEPTH_LOG2, 2, log2 of descriptor FIFO depth (depth 4); CYC_BWIDTH, 32, cycle counter width; TIMEOUT_CYCLES, 100000, WAIT cycle limit.
REQ-003 CLK  in  1  sole clock; all logic on rising edge.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 JOB_VALID_in  in  1  descriptor offered.
REQ-006 JOB_READY_out  out  1  descriptor FIFO not full.
REQ-007 JOB_M_in / JOB_K_in / JOB_N_in  in  MAX_*_SIZE_LOG2  descriptor matrix sizes.
REQ-008 START_out  out  1  one-cycle start pulse to the systolic array.
REQ-009 M_SIZE_out / K_SIZE_out / N_SIZE_out  out  MAX_*_SIZE_LOG2  sizes to the array.
REQ-010 STALL_out  out  1  array stall; tied to 0.
REQ-011 IS_FINISHED_in  in  1  completion from the array.
REQ-012 DONE_VALID_out  out  1  completion report valid.
REQ-013 DONE_READY_in  in  1  report consumed.
REQ-014 DONE_CYCLES_out  out  CYC_BWIDTH  WAIT cycles counted for the job.
REQ-015 DONE_STATUS_out  out  2  00 ok, 01 timeout, 10 zero-size, 11 unused.
REQ-016 BUSY_out  out  1  state not IDLE or FIFO not empty.
REQ-017 JOB_COUNT_out  out  16  reports consumed, wraps at 2^16.

Function
REQ-018 Descriptor FIFO: push when JOB_VALID_in && JOB_READY_out; JOB_READY_out = (occupancy < depth), derived from registered occupancy only.
REQ-019 Push and pop in the same cycle SHALL both occur, occupancy unchanged; no push when full, no pop when empty; FIFO order preserved across pointer wrap.
REQ-020 FSM states: IDLE, LAUNCH, WAIT, REPORT.
REQ-021 IDLE: FIFO non-empty -> pop head, latch sizes into M/K/N_SIZE_out; any size 0 -> REPORT with status 10 and cycles 0; else -> LAUNCH.
REQ-022 LAUNCH: START_out = 1 for exactly this cycle; cycle counter cleared to 0; -> WAIT.
REQ-023 WAIT: counter increments by 1 every cycle, saturating at all-ones; IS_FINISHED_in = 1 -> REPORT, status 00, DONE_CYCLES_out = counter incl. that cycle.
REQ-024 WAIT: counter reaching TIMEOUT_CYCLES without IS_FINISHED_in -> REPORT, status 01, DONE_CYCLES_out = TIMEOUT_CYCLES; IS_FINISHED_in on that same cycle takes priority (status 00).
REQ-025 REPORT: DONE_VALID_out = 1; DONE_CYCLES_out, DONE_STATUS_out stable until DONE_READY_in = 1; then JOB_COUNT_out increments and -> IDLE.
REQ-026 IS_FINISHED_in SHALL be ignored outside WAIT.
REQ-027 M/K/N_SIZE_out SHALL hold their values from the IDLE pop through the end of REPORT and beyond, until the next pop.
REQ-028 Latency: descriptor pushed into an empty FIFO while IDLE at edge t -> pop in cycle t+1, START_out = 1 in cycle t+2.
REQ-029 Minimum job turnaround: REPORT accepted in cycle r -> next START_out no earlier than cycle r+2.
REQ-030 FIFO pushes SHALL continue to be accepted in every FSM state.

Reset
REQ-031 RST = 1 at a rising edge: state IDLE, FIFO empty, counter 0; START_out, DONE_VALID_out, BUSY_out 0; DONE_CYCLES_out, DONE_STATUS_out, size outputs, JOB_COUNT_out 0; JOB_READY_out 1 on the following cycle.
REQ-032 Reset mid-job (LAUNCH/WAIT/REPORT) SHALL abandon the job without a report and discard queued descriptors.
REQ-033 A push offered during the RST cycle SHALL be dropped.

Verification
REQ-034 Push (128,128,128); IS_FINISHED_in pulsed on 5th WAIT cycle -> one START_out pulse 2 cycles after push, report cycles=5, status 00, JOB_COUNT_out=1.
REQ-035 Push 5 descriptors back-to-back while array never finishes -> JOB_READY_out low after 4th, 5th not accepted; 4 jobs launched in push order.
REQ-036 TIMEOUT_CYCLES=20, no IS_FINISHED_in -> report cycles=20, status 01; IS_FINISHED_in on exactly cycle 20 -> status 00.
REQ-037 Push (0,64,64) -> no START_out, report cycles=0, status 10.
REQ-038 DONE_READY_in held low 10 cycles in REPORT -> DONE_VALID_out and payload stable, no new START_out; stray IS_FINISHED_in in IDLE -> no effect.
REQ-039 RST asserted in WAIT with 2 queued jobs -> all outputs zero next cycle, no report, no further START_out.
